mul_share_arbiter: RTL and testbench

Round-robin arbiter that shares one sequential shift-add multiplier between two requesters. In the cube-root/add system, the squaring path and the cube-root iteration path both compete for this multiplier. Each requester sends an operand pair. The arbiter grants the multiplier to one requester at a time, runs the multiply, and returns the product with a one-cycle done pulse. The multiplier itself is the only arithmetic inside the block.

---
 rtl/mul_arb_pkg.sv | 24 ++
 rtl/mul_share_arbiter_if.sv | 32 +++
 rtl/mul_shift_add.sv | 61 ++++++
 rtl/mul_share_arbiter.sv | 113 +++++++++++
 tb/tb_mul_share_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared constants for the multiplier-sharing arbiter.
//   state_e      - arbiter FSM state encoding (IDLE, WORK, DONE)
//   DEF_WIDTH    - default operand width
//   NUM_REQ      - number of requesters sharing the multiplier
//   pick_winner  - round-robin choice between the two requesters
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int NUM_REQ   = 2;

  // Returns the index of the winning requester. On a tie the requester
  // that was not served last wins; a lone request always wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: requester/result bundle of the arbiter.
//   req*_i, a*_bi, b*_bi : request level and operand pair per requester
//   done*_o, y*_bo       : one-cycle done pulse and held product per requester
//   gnt_bo               : one-hot current owner, 00 when idle
//   busy_o               : arbiter not idle
// Modports: slave = arbiter side, master = requester side.
interface mul_share_arbiter_if #(
  parameter int WIDTH = mul_arb_pkg::DEF_WIDTH
);
  logic               req0_i;
  logic [WIDTH-1:0]   a0_bi;
  logic [WIDTH-1:0]   b0_bi;
  logic               req1_i;
  logic [WIDTH-1:0]   a1_bi;
  logic [WIDTH-1:0]   b1_bi;
  logic               done0_o;
  logic [2*WIDTH-1:0] y0_bo;
  logic               done1_o;
  logic [2*WIDTH-1:0] y1_bo;
  logic [1:0]         gnt_bo;
  logic               busy_o;

  modport slave (
    input  req0_i, a0_bi, b0_bi, req1_i, a1_bi, b1_bi,
    output done0_o, y0_bo, done1_o, y1_bo, gnt_bo, busy_o
  );

  modport master (
    output req0_i, a0_bi, b0_bi, req1_i, a1_bi, b1_bi,
    input  done0_o, y0_bo, done1_o, y1_bo, gnt_bo, busy_o
  );
endinterface

// File: rtl/mul_shift_add.sv
// mul_shift_add: sequential unsigned shift-add multiplier, one bit per cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : load operands; bit 0 of b is consumed on this edge
//   a_bi, b_bi   : operands (sampled only with start_i)
//   y_bo         : product, valid and held once busy_o drops
//   busy_o       : high from the start edge until the product is valid
// The start edge handles the first multiplier bit, so the remaining
// WIDTH-1 bits take WIDTH-1 more edges: WIDTH cycles in total.
module mul_shift_add #(
  parameter int WIDTH = mul_arb_pkg::DEF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  output logic [2*WIDTH-1:0] y_bo,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = b_bi[0] ? {{WIDTH{1'b0}}, a_bi} : '0;
      mcand_d  = {{WIDTH{1'b0}}, a_bi} << 1;
      mplier_d = b_bi >> 1;
      cnt_d    = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign y_bo   = acc_q;
  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one shift-add multiplier
// between two requesters.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : requests/operands in; done pulses, held products,
//                  one-hot grant and busy out
// Flow: IDLE samples requests and starts the multiplier on the grant
// edge, WORK waits for the multiplier, DONE registers the product and
// raises the winner's done for the following (IDLE) cycle.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mul_share_arbiter_if.slave bus
);
  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 win_q, win_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2*WIDTH-1:0]   y0_q, y0_d, y1_q, y1_d;
  logic                 done0_q, done0_d, done1_q, done1_d;

  logic                 win_now;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic [2*WIDTH-1:0]   mul_y;
  logic                 mul_busy;

  // Winner and its operands are combinational so the multiplier can
  // capture them directly on the grant edge.
  assign win_now = pick_winner(bus.req0_i, bus.req1_i, last_q);
  assign mul_a   = win_now ? bus.a1_bi : bus.a0_bi;
  assign mul_b   = win_now ? bus.b1_bi : bus.b0_bi;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(mul_start),
    .a_bi   (mul_a),
    .b_bi   (mul_b),
    .y_bo   (mul_y),
    .busy_o (mul_busy)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0_i || bus.req1_i) begin
          win_d     = win_now;
          gnt_d     = win_now ? 2'b10 : 2'b01;
          mul_start = 1'b1;
          state_d   = ST_WORK;
        end
      end
      ST_WORK: begin
        if (!mul_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (win_q) begin
          y1_d    = mul_y;
          done1_d = 1'b1;
        end else begin
          y0_d    = mul_y;
          done0_d = 1'b1;
        end
        last_d  = win_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      gnt_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign bus.done0_o = done0_q;
  assign bus.done1_o = done1_q;
  assign bus.y0_bo   = y0_q;
  assign bus.y1_bo   = y1_q;
  assign bus.gnt_bo  = gnt_q;
  assign bus.busy_o  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
  localparam int W = 8;

  typedef struct {
    bit          id;
    logic [15:0] y;
  } exp_t;

  logic clk_i;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  mul_share_arbiter_if #(.WIDTH(W)) bus ();

  mul_share_arbiter #(.WIDTH(W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after the grant edge. Waits for a done pulse, checks its
  // latency, that only one done is high, and the product against the
  // scoreboard. Optionally watches that y0 holds a value throughout.
  task automatic serve(input string tag, input bit watch_y0,
                       input logic [15:0] y0_hold);
    int   n;
    bit   seen;
    exp_t e;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (watch_y0) chk({tag, " y0_hold"}, bus.y0_bo, y0_hold);
      if (bus.done0_o || bus.done1_o) seen = 1;
    end
    chk({tag, " latency"}, n, W + 1);
    if (seen) begin
      chk({tag, " one_done"}, bus.done0_o & bus.done1_o, 0);
      chk({tag, " sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " done_id"}, bus.done1_o, e.id);
        chk({tag, " y"}, e.id ? bus.y1_bo : bus.y0_bo, e.y);
      end
      chk({tag, " busy_fall"}, bus.busy_o, 0);
      chk({tag, " gnt_idle"}, bus.gnt_bo, 0);
    end
  endtask

  task automatic push(input bit id, input int a, input int b);
    exp_t e;
    e.id = id;
    e.y  = 16'(a * b);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    chk("rst gnt", bus.gnt_bo, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst done0", bus.done0_o, 0);
    chk("rst done1", bus.done1_o, 0);
    chk("rst y0", bus.y0_bo, 0);
    chk("rst y1", bus.y1_bo, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    bit any_done;
    rst_i = 1'b1;
    bus.req0_i = 0; bus.a0_bi = '0; bus.b0_bi = '0;
    bus.req1_i = 0; bus.a1_bi = '0; bus.b1_bi = '0;

    // 1: single job, explicit busy window
    do_reset();
    bus.a0_bi = 8'd12; bus.b0_bi = 8'd13; bus.req0_i = 1;
    push(0, 12, 13);
    tick();
    chk("t1 gnt", bus.gnt_bo, 2'b01);
    chk("t1 busy_k", bus.busy_o, 1);
    for (int i = 1; i <= W; i++) begin
      tick();
      chk("t1 busy_win", bus.busy_o, 1);
      chk("t1 no_early_done", bus.done0_o, 0);
    end
    tick();
    chk("t1 done0", bus.done0_o, 1);
    chk("t1 busy_low", bus.busy_o, 0);
    chk("t1 y0", bus.y0_bo, 156);
    chk("t1 y1", bus.y1_bo, 0);
    void'(sb.pop_front());
    bus.req0_i = 0;
    tick();
    chk("t1 done0_once", bus.done0_o, 0);
    chk("t1 y0_held", bus.y0_bo, 156);
    chk("t1 gnt_idle", bus.gnt_bo, 0);

    // 2: simultaneous requests from reset (last = 1, so 0 wins)
    do_reset();
    bus.a0_bi = 8'd255; bus.b0_bi = 8'd255; bus.req0_i = 1;
    bus.a1_bi = 8'd3;   bus.b1_bi = 8'd7;   bus.req1_i = 1;
    push(0, 255, 255);
    push(1, 3, 7);
    tick();
    chk("t2 gnt0", bus.gnt_bo, 2'b01);
    serve("t2 job0", 0, 0);
    bus.req0_i = 0;
    tick();
    chk("t2 gnt1", bus.gnt_bo, 2'b10);
    serve("t2 job1", 0, 0);
    bus.req1_i = 0;
    tick();

    // 3: fairness with both requests held
    bus.a0_bi = 8'd5; bus.b0_bi = 8'd6;
    bus.a1_bi = 8'd7; bus.b1_bi = 8'd9;
    bus.req0_i = 1; bus.req1_i = 1;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) push(0, 5, 6); else push(1, 7, 9);
      tick();
      chk("t3 gnt", bus.gnt_bo, (j % 2 == 0) ? 2'b01 : 2'b10);
      serve("t3 job", 0, 0);
    end
    bus.req0_i = 0; bus.req1_i = 0;
    tick();

    // 4: zero operand, y0 must hold 30
    bus.a1_bi = 8'd0; bus.b1_bi = 8'd200; bus.req1_i = 1;
    push(1, 0, 200);
    tick();
    chk("t4 gnt", bus.gnt_bo, 2'b10);
    serve("t4 job", 1, 16'd30);
    bus.req1_i = 0;
    tick();
    chk("t4 y0_after", bus.y0_bo, 30);

    // 5: reset during the 3rd WORK cycle of a requester-1 job
    bus.a1_bi = 8'd9; bus.b1_bi = 8'd9; bus.req1_i = 1;
    tick();
    chk("t5 gnt", bus.gnt_bo, 2'b10);
    tick();
    tick();
    rst_i = 1'b1;
    bus.req1_i = 0;
    tick();
    chk("t5 busy", bus.busy_o, 0);
    chk("t5 gnt_clr", bus.gnt_bo, 0);
    chk("t5 done", bus.done0_o | bus.done1_o, 0);
    chk("t5 y0", bus.y0_bo, 0);
    chk("t5 y1", bus.y1_bo, 0);
    rst_i = 1'b0;
    any_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (bus.done0_o || bus.done1_o) any_done = 1;
    end
    chk("t5 abandoned", any_done, 0);
    bus.a0_bi = 8'd4; bus.b0_bi = 8'd4; bus.req0_i = 1;
    push(0, 4, 4);
    tick();
    chk("t5 fresh_gnt", bus.gnt_bo, 2'b01);
    serve("t5 fresh", 0, 0);
    bus.req0_i = 0;
    tick();
    chk("sb drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
